// File: rtl/pitch_frame_writer_pkg.sv
// Shared analyzer definitions: frame-writer state encoding, sample widths and
// the default upper clamp for written song frequencies.
package pitch_frame_writer_pkg;

    localparam int HZ_W   = 15;
    localparam int DROP_W = 8;

    localparam logic [HZ_W-1:0] DEFAULT_MAX_HZ = 15'd20000;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PITCH,
        FETCH,
        CAPTURE,
        WRITE,
        FINISH
    } state_t;

    // Out-of-range detections are pinned to the ceiling; unvoiced (0) passes through.
    function automatic logic [HZ_W-1:0] clamp_hz(input logic [HZ_W-1:0] hz,
                                                 input logic [HZ_W-1:0] max_hz);
        return (hz > max_hz) ? max_hz : hz;
    endfunction

endpackage

// File: rtl/pitch_frame_writer.sv
// Pairs each detected pitch with its reference note from ROM and writes both
// into the song/reference FIFOs together, one frame per detected pitch.
module pitch_frame_writer
    import pitch_frame_writer_pkg::*;
#(
    parameter int              LEN_W  = 12,
    parameter logic [HZ_W-1:0] MAX_HZ = DEFAULT_MAX_HZ
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  song_len,
    input  logic              pitch_valid,
    input  logic [HZ_W-1:0]   pitch_hz,
    output logic              ref_rd_en,
    output logic [LEN_W-1:0]  ref_addr,
    input  logic [HZ_W-1:0]   ref_hz,
    input  logic              song_full,
    input  logic              ref_full,
    output logic              song_wr_en,
    output logic              ref_wr_en,
    output logic [HZ_W-1:0]   song_din,
    output logic [HZ_W-1:0]   ref_din,
    output logic              busy,
    output logic              done,
    output logic [DROP_W-1:0] drop_count
);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, idx_q, idx_inc;
    logic              hold_valid_q;
    logic [HZ_W-1:0]   hold_hz_q, cur_hz_q, song_q, ref_q;
    logic              busy_q, done_q;
    logic [DROP_W-1:0] drop_q;

    logic accept, consume, capture, write, finish;
    logic bypass, drop, load;

    assign idx_inc = idx_q + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        consume = 1'b0;
        capture = 1'b0;
        write   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (song_len == '0) ? FINISH : WAIT_PITCH;
                end
            end
            WAIT_PITCH: begin
                if (hold_valid_q || pitch_valid) begin
                    consume = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH:   state_d = CAPTURE;
            CAPTURE: begin
                capture = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                if (!(song_full || ref_full)) begin
                    write   = 1'b1;
                    state_d = (idx_inc == len_q) ? FINISH : WAIT_PITCH;
                end
            end
            FINISH: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A sample consumed straight from the strobe never touches the holding register.
        bypass = consume && !hold_valid_q;
        drop   = (state_q != IDLE) && pitch_valid && hold_valid_q && !consume;
        load   = (state_q != IDLE) && pitch_valid && !bypass && !drop;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q        <= '0;
            idx_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_hz_q    <= '0;
            cur_hz_q     <= '0;
            song_q       <= '0;
            ref_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            drop_q       <= '0;
        end else begin
            done_q <= finish;
            if (accept) begin
                len_q  <= song_len;
                idx_q  <= '0;
                busy_q <= 1'b1;
            end
            if (finish) busy_q <= 1'b0;

            if (consume) cur_hz_q <= hold_valid_q ? hold_hz_q : pitch_hz;
            if (capture) begin
                song_q <= clamp_hz(cur_hz_q, MAX_HZ);
                ref_q  <= ref_hz;
            end
            if (write) idx_q <= idx_inc;

            if (load) begin
                hold_valid_q <= 1'b1;
                hold_hz_q    <= pitch_hz;
            end else if (consume) begin
                hold_valid_q <= 1'b0;
            end
            if (drop && drop_q != '1) drop_q <= drop_q + DROP_W'(1);
        end
    end

    // Outputs are forced quiet while rst is high, even before the state register clears.
    assign ref_rd_en  = (state_q == FETCH) && !rst;
    assign song_wr_en = write && !rst;
    assign ref_wr_en  = write && !rst;
    assign ref_addr   = rst ? '0 : idx_q;
    assign song_din   = rst ? '0 : song_q;
    assign ref_din    = rst ? '0 : ref_q;
    assign busy       = busy_q && !rst;
    assign done       = done_q && !rst;
    assign drop_count = rst ? '0 : drop_q;

endmodule

// File: doc/pitch_frame_writer.md
PITCH_FRAME_WRITER -- requirements
Module: pitch_frame_writer

Interface
REQ-001 SHALL have parameter LEN_W, default 12: width of frame count and reference address.
REQ-002 SHALL have parameter MAX_HZ, default 15'd20000: upper clamp for written song frequency.
REQ-003 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port start  input  1: one-cycle pulse that begins a song run.
REQ-006 SHALL have port song_len  input  LEN_W: frames in the run; sampled on accepted start.
REQ-007 SHALL have port pitch_valid  input  1: one-cycle strobe from the pitch detector.
REQ-008 SHALL have port pitch_hz  input  15: detected frequency in Hz; 0 means unvoiced.
REQ-009 SHALL have port ref_rd_en  output  1: read strobe to the reference note ROM.
REQ-010 SHALL have port ref_addr  output  LEN_W: ROM address, equal to the current frame index.
REQ-011 SHALL have port ref_hz  input  15: ROM data, valid the cycle after ref_rd_en.
REQ-012 SHALL have port song_full, ref_full  input  1 each: full flags of the song and reference FIFOs.
REQ-013 SHALL have port song_wr_en, ref_wr_en  output  1 each: FIFO write strobes.
REQ-014 SHALL have port song_din, ref_din  output  15 each: FIFO write data in Hz.
REQ-015 SHALL have port busy  output  1: high from accepted start until done.
REQ-016 SHALL have port done  output  1: one-cycle pulse when the run completes.
REQ-017 SHALL have port drop_count  output  8: count of discarded pitch strobes, saturating.

Function
REQ-018 SHALL implement states IDLE, WAIT_PITCH, FETCH, CAPTURE, WRITE, FINISH.
REQ-019 IDLE with start=1 SHALL latch song_len, clear the frame index, and go to WAIT_PITCH; if song_len=0, go to FINISH instead.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 SHALL keep a one-entry pitch holding register; pitch_valid writes it when empty, in any state except IDLE.
REQ-022 pitch_valid while the holding register is full and not being consumed that cycle SHALL drop the sample and increment drop_count, saturating at 255.
REQ-023 pitch_valid in IDLE SHALL be ignored and not counted.
REQ-024 WAIT_PITCH with the holding register full (or pitch_valid=1) SHALL consume the sample and go to FETCH.
REQ-025 FETCH SHALL assert ref_rd_en for exactly one cycle, with ref_addr = frame index, then go to CAPTURE.
REQ-026 CAPTURE SHALL register ref_hz and the clamped pitch (pitch_hz > MAX_HZ gives MAX_HZ; 0 is kept as 0), then go to WRITE.
REQ-027 In WRITE, song_wr_en and ref_wr_en SHALL both equal !(song_full | ref_full), combinationally; they are never asserted separately.
REQ-028 song_din and ref_din SHALL be stable from CAPTURE exit until the write completes.
REQ-029 On a write cycle, the frame index SHALL increment; if index+1 == latched length, go to FINISH, else go to WAIT_PITCH.
REQ-030 FINISH SHALL pulse done for one cycle, deassert busy, and go to IDLE.
REQ-031 Minimum latency SHALL be: pitch_valid at cycle N in WAIT_PITCH gives ref_rd_en at N+1 and wr_en at N+3.
REQ-032 The frame index SHALL never wrap; run length is at most 2^LEN_W-1.

Reset
REQ-033 rst=1 SHALL force IDLE and clear the index, length, holding register and drop_count.
REQ-034 During and after rst, all strobes and data outputs SHALL be 0, busy=0 and done=0, including when rst occurs mid-run.
REQ-035 rst SHALL take priority over start and pitch_valid in the same cycle.

Structure
REQ-036 State encoding and the default MAX_HZ value SHALL live in the shared analyzer package used by the comparison and tally blocks.
REQ-037 The block SHALL be a single module with no sub-modules; the holding register is inline logic.

Verification
REQ-038 start, song_len=3, three pitch strobes 440/0/25000 spaced 10 cycles apart, ROM returns addr*100+1 -> song_din 440, 0, 20000; ref_din 1, 101, 201; one done pulse; drop_count=0.
REQ-039 song_full=1 held for 5 cycles in WRITE -> no wr_en on either FIFO; both strobes assert together on the first cycle full clears; data unchanged.
REQ-040 Three pitch strobes on consecutive cycles while in FETCH -> one sample held, drop_count=2, and the next frame uses the held value.
REQ-041 start with song_len=0 -> done pulses two cycles later; no ref_rd_en and no wr_en.
REQ-042 rst asserted in WRITE with ref_full=1 -> next cycle busy=0, wr_en=0, drop_count=0; a new start runs normally from frame 0.
REQ-043 start pulsed again mid-run -> ignored; total writes still equal the first song_len.
